// File: rtl/alu_seq.sv
// Sequential ALU: one op per valid/ready handshake, iterative shifts (1 bit/cycle) and shift-add multiply.
// Result and Z/C/N/V flags are registered and held in DONE until out_ready; c also feeds ADC as carry-in.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             z,
  output logic             c,
  output logic             n,
  output logic             v
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_CLR = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_ADC = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_SAR = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [WIDTH-1:0]     work_q, work_d;   // shift operand, or remaining multiplier bits
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     f_q, f_d;
  logic                 c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;

  logic [SHW-1:0]       k;
  logic                 is_shift;
  logic [WIDTH:0]       sum_w;
  logic [WIDTH-1:0]     res_f;
  logic                 res_c, res_v;
  logic [WIDTH-1:0]     sh_w;
  logic                 sh_c;
  logic [2*WIDTH-1:0]   mac;

  assign k        = b[SHW-1:0];
  assign is_shift = (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR);

  // Single-cycle results straight from the request inputs; a zero-distance shift is a plain copy.
  always_comb begin
    sum_w = '0;
    res_f = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op)
      OP_CLR: res_f = '0;
      OP_ADD, OP_ADC: begin
        sum_w = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) && c_q};
        res_f = sum_w[WIDTH-1:0];
        res_c = sum_w[WIDTH];
        res_v = (a[WIDTH-1] == b[WIDTH-1]) && (res_f[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sum_w = {1'b0, a} - {1'b0, b};
        res_f = sum_w[WIDTH-1:0];
        res_c = ~sum_w[WIDTH];
        res_v = (a[WIDTH-1] != b[WIDTH-1]) && (res_f[WIDTH-1] != a[WIDTH-1]);
      end
      OP_OR:  res_f = a | b;
      OP_AND: res_f = a & b;
      OP_XOR: res_f = a ^ b;
      OP_NOT: res_f = ~a;
      OP_SHL, OP_SHR, OP_SAR: res_f = a;
      OP_MUL: res_f = '0;
      default: res_f = '1;
    endcase
  end

  always_comb begin
    sh_w = work_q;
    sh_c = 1'b0;
    case (op_q)
      OP_SHL: begin
        sh_w = {work_q[WIDTH-2:0], 1'b0};
        sh_c = work_q[WIDTH-1];
      end
      OP_SHR: begin
        sh_w = {1'b0, work_q[WIDTH-1:1]};
        sh_c = work_q[0];
      end
      default: begin
        sh_w = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        sh_c = work_q[0];
      end
    endcase
    mac = acc_q + (work_q[0] ? mcand_q : '0);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    c_d     = c_q;
    v_d     = v_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = op;
          if (op == OP_MUL) begin
            acc_d   = '0;
            mcand_d = {{WIDTH{1'b0}}, a};
            work_d  = b;
            cnt_d   = CW'(WIDTH);
            state_d = BUSY;
          end else if (is_shift && (k != '0)) begin
            work_d  = a;
            cnt_d   = CW'(k);
            state_d = BUSY;
          end else begin
            f_d     = res_f;
            c_d     = res_c;
            v_d     = res_v;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (op_q == OP_MUL) begin
          acc_d   = mac;
          mcand_d = mcand_q << 1;
          work_d  = work_q >> 1;
        end else begin
          work_d = sh_w;
        end
        if (cnt_q == CW'(1)) begin
          f_d     = (op_q == OP_MUL) ? mac[WIDTH-1:0] : sh_w;
          c_d     = (op_q == OP_MUL) ? |mac[2*WIDTH-1:WIDTH] : sh_c;
          v_d     = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    z_d = (f_d == '0);
    n_d = f_d[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      work_q  <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      f_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b1;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign f = f_q;
  assign z = z_q;
  assign c = c_q;
  assign n = n_q;
  assign v = v_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): expected results queued at issue, popped when out_valid rises.
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready;
  logic [3:0] op;
  logic [7:0] a, b, f;
  logic       in_ready, out_valid, z, c, n, v;

  int checks = 0;
  int errors = 0;

  typedef struct {logic [11:0] flags; int lat; string name;} exp_t;
  typedef struct {logic [3:0] op; logic [7:0] a; logic [7:0] b;} stim_t;
  exp_t  sb[$];
  stim_t stim_q[$];

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .z(z), .c(c), .n(n), .v(v)
  );

  always #5 clk = ~clk;

  // Expected flags packed as {f, c, v, z, n}; z and n derived from the expected f.
  task automatic issue(input string nm, input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb,
                       input logic [7:0] ef, input logic ec, input logic ev, input int lat);
    exp_t  e;
    stim_t s;
    e.flags = {ef, ec, ev, (ef == 8'h00), ef[7]};
    e.lat   = lat;
    e.name  = nm;
    s.op = o; s.a = xa; s.b = xb;
    sb.push_back(e);
    stim_q.push_back(s);
  endtask

  task automatic run_op(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb,
                        output logic [11:0] got, output int lat);
    op = o; a = xa; b = xb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    got = {f, c, v, z, n};
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_handshake: in_ready/out_valid got %b%b expected 10", in_ready, out_valid);
    end
    checks++;
    if ({f, c, v, z, n} !== {8'h00, 4'b0010}) begin
      errors++;
      $display("FAIL reset_flags: f/c/v/z/n got %h_%b%b%b%b expected 00_0010", f, c, v, z, n);
    end
  endtask

  task automatic test_arith();
    logic [11:0] got;
    int lat;
    stim_t s;
    exp_t e;
    issue("add_carry",   4'd1,  8'hF0, 8'h20, 8'h10, 1, 0, 1);
    issue("adc_cprev",   4'd6,  8'h01, 8'h01, 8'h03, 0, 0, 1);
    issue("sub_equal",   4'd2,  8'h05, 8'h05, 8'h00, 1, 0, 1);
    issue("sub_borrow",  4'd2,  8'h03, 8'h05, 8'hFE, 0, 0, 1);
    issue("add_ovf",     4'd1,  8'h7F, 8'h01, 8'h80, 0, 1, 1);
    issue("sub_ovf",     4'd2,  8'h80, 8'h01, 8'h7F, 1, 1, 1);
    issue("or",          4'd3,  8'hA5, 8'h0F, 8'hAF, 0, 0, 1);
    issue("and",         4'd4,  8'hA5, 8'h0F, 8'h05, 0, 0, 1);
    issue("xor",         4'd5,  8'hA5, 8'hFF, 8'h5A, 0, 0, 1);
    issue("not",         4'd7,  8'h0F, 8'h33, 8'hF0, 0, 0, 1);
    issue("clr",         4'd0,  8'h5A, 8'hA5, 8'h00, 0, 0, 1);
    issue("reserved15",  4'd15, 8'h12, 8'h34, 8'hFF, 0, 0, 1);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      run_op(s.op, s.a, s.b, got, lat);
      e = sb.pop_front();
      checks++;
      if (got !== e.flags) begin
        errors++;
        $display("FAIL %s: f/c/v/z/n got %h_%b expected %h_%b", e.name, got[11:4], got[3:0], e.flags[11:4], e.flags[3:0]);
      end
      checks++;
      if (lat !== e.lat) begin
        errors++;
        $display("FAIL %s_latency: got %0d expected %0d", e.name, lat, e.lat);
      end
      consume();
    end
  endtask

  task automatic test_shift();
    logic [11:0] got;
    int lat;
    stim_t s;
    exp_t e;
    issue("shl_3",      4'd8,  8'h81, 8'h03, 8'h08, 0, 0, 4);
    issue("sar_2",      4'd10, 8'h90, 8'h02, 8'hE4, 0, 0, 3);
    issue("shr_0",      4'd9,  8'h03, 8'h00, 8'h03, 0, 0, 1);
    issue("shr_hi_b",   4'd9,  8'h81, 8'hF9, 8'h40, 1, 0, 2);
    issue("shl_7",      4'd8,  8'h03, 8'h07, 8'h80, 1, 0, 8);
    issue("sar_1",      4'd10, 8'h81, 8'h01, 8'hC0, 1, 0, 2);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      run_op(s.op, s.a, s.b, got, lat);
      e = sb.pop_front();
      checks++;
      if (got !== e.flags) begin
        errors++;
        $display("FAIL %s: f/c/v/z/n got %h_%b expected %h_%b", e.name, got[11:4], got[3:0], e.flags[11:4], e.flags[3:0]);
      end
      checks++;
      if (lat !== e.lat) begin
        errors++;
        $display("FAIL %s_latency: got %0d expected %0d", e.name, lat, e.lat);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] got;
    int lat;
    exp_t e;
    issue("bp_add", 4'd1, 8'h12, 8'h34, 8'h46, 0, 0, 1);
    void'(stim_q.pop_front());
    run_op(4'd1, 8'h12, 8'h34, got, lat);
    e = sb.pop_front();
    checks++;
    if (got !== e.flags || lat !== e.lat) begin
      errors++;
      $display("FAIL bp_result: f/c/v/z/n got %h_%b lat %0d expected %h_%b lat %0d",
               got[11:4], got[3:0], lat, e.flags[11:4], e.flags[3:0], e.lat);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = 4'd15; a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({f, c, v, z, n} !== e.flags || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d: f/c/v/z/n %h_%b%b%b%b in_ready %b out_valid %b expected %h_%b 0 1",
                 i, f, c, v, z, n, in_ready, out_valid, e.flags[11:4], e.flags[3:0]);
      end
    end
    in_valid = 1'b0;
    consume();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release: in_ready/out_valid got %b%b expected 10", in_ready, out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_ignored_req: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_mul();
    logic [11:0] got;
    int lat;
    stim_t s;
    exp_t e;
    issue("mul_small",  4'd11, 8'h0F, 8'h03, 8'h2D, 0, 0, 9);
    issue("mul_ffff",   4'd11, 8'hFF, 8'hFF, 8'h01, 1, 0, 9);
    issue("mul_hi",     4'd11, 8'h10, 8'h11, 8'h10, 1, 0, 9);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      run_op(s.op, s.a, s.b, got, lat);
      e = sb.pop_front();
      checks++;
      if (got !== e.flags) begin
        errors++;
        $display("FAIL %s: f/c/v/z/n got %h_%b expected %h_%b", e.name, got[11:4], got[3:0], e.flags[11:4], e.flags[3:0]);
      end
      checks++;
      if (lat !== e.lat) begin
        errors++;
        $display("FAIL %s_latency: got %0d expected %0d", e.name, lat, e.lat);
      end
      consume();
    end
  endtask

  task automatic test_reset_mid_op();
    logic [11:0] got;
    int lat;
    bit seen;
    stim_t s;
    exp_t e;
    op = 4'd11; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mul_busy: in_ready got %b expected 0", in_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, f, c, z} !== {2'b10, 8'h00, 2'b01}) begin
      errors++;
      $display("FAIL reset_mid_op: in_ready %b out_valid %b f %h c %b z %b expected 1 0 00 0 1",
               in_ready, out_valid, f, c, z);
    end
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abandoned_op: out_valid seen %b expected 0", seen);
    end
    issue("adc_after_rst", 4'd6,  8'h01, 8'h01, 8'h02, 0, 0, 1);
    issue("reserved13",    4'd13, 8'h5A, 8'h3C, 8'hFF, 0, 0, 1);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      run_op(s.op, s.a, s.b, got, lat);
      e = sb.pop_front();
      checks++;
      if (got !== e.flags) begin
        errors++;
        $display("FAIL %s: f/c/v/z/n got %h_%b expected %h_%b", e.name, got[11:4], got[3:0], e.flags[11:4], e.flags[3:0]);
      end
      checks++;
      if (lat !== e.lat) begin
        errors++;
        $display("FAIL %s_latency: got %0d expected %0d", e.name, lat, e.lat);
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_backpressure();
    test_mul();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, sequential successor to the team's 4-bit combinational ALU.
- Accepts one operation per valid/ready handshake, computes single-cycle ops in one cycle and barrel-free shifts and multiply iteratively, then holds a registered result with Z/C/N/V flags until it is consumed.
- Sits between the datapath sequencer and the register file.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).
- SHW, $clog2(WIDTH), width of the shift-amount field taken from b.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- op  input  4  opcode.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (shift amount = b[SHW-1:0]).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- f  output  WIDTH  result.
- z  output  1  zero flag, f == 0.
- c  output  1  carry/borrow/shift-out flag.
- n  output  1  negative flag, f[WIDTH-1].
- v  output  1  signed overflow flag.

Behaviour:
- Reset: rst sampled on the clk edge.
  - State goes to IDLE; in_ready=1; out_valid=0; f=0; c=0; v=0; n=0; z=1.
  - Reset mid-operation abandons the op; no result is ever presented for it.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid, latch op/a/b. Single-cycle ops go to DONE next edge; iterative ops go to BUSY.
  - BUSY: in_ready=0, out_valid=0. One step per cycle. Go to DONE on the edge the final step completes.
  - DONE: out_valid=1, in_ready=0. f/flags are stable. On out_ready go to IDLE next edge. No new request is accepted in the same cycle, so peak throughput is 1 op / 2 cycles.
- Opcodes and results (all arithmetic is unsigned WIDTH-bit unless noted; c, v=0 unless stated):
  - 0 CLR: f=0.
  - 1 ADD: {c,f}=a+b; v=signed overflow.
  - 2 SUB: {x,f}={0,a}-{0,b}; c=~x, so c=1 means no borrow and a==b gives c=1; v=signed overflow.
  - 3 OR.
  - 4 AND.
  - 5 XOR.
  - 6 ADC: {c,f}=a+b+c_prev, where c_prev is the c register from the last completed op; v as ADD.
  - 7 NOT: f=~a.
  - 8 SHL: shift a left by k=b[SHW-1:0], one bit per BUSY cycle. c=last bit shifted out; k=0 gives f=a, c=0, and the op is treated as single-cycle.
  - 9 SHR: as SHL but logical right; c=last bit out.
  - 10 SAR: arithmetic right; sign replicated; c=last bit out.
  - 11 MUL: low WIDTH bits of a*b by shift-add, exactly WIDTH BUSY cycles. c=1 if any discarded high product bit is non-zero.
  - 12–15 reserved: single-cycle, f=all ones, c=0, v=0.
- Latency, accept edge to out_valid high:
  - Single-cycle ops: 1 cycle.
  - Shifts: k+1 cycles.
  - MUL: WIDTH+1 cycles.
- Flag computation: z and n are always computed from the final f. v is defined only for ADD/SUB/ADC and is 0 for every other op.
- Outputs are registered. Inputs a, b, op are don't-care outside the accepting cycle, and changes to them never disturb an in-flight op.
- in_valid while not in IDLE is ignored, because the handshake did not fire.
- c_prev persists across ops and resets to 0.

Test Plan:
- WIDTH=8, ADD a=0xF0 b=0x20 → f=0x10, c=1, v=0, z=0; out_valid rises 1 cycle after accept. Then ADC a=0x01 b=0x01 → f=0x03, c=0.
- SUB a=0x05 b=0x05 → f=0x00, z=1, c=1. SUB a=0x03 b=0x05 → f=0xFE, c=0, n=1. ADD a=0x7F b=0x01 → f=0x80, v=1, n=1.
- SHL a=0x81 b=3 → f=0x08, c=0, latency 4 cycles. SAR a=0x90 b=2 → f=0xE4, c=0. SHR a=0x03 b=0 → f=0x03, c=0, latency 1.
- MUL a=0x10 b=0x11 → f=0x10, c=1, latency 9 cycles. MUL a=0x0F b=0x03 → f=0x2D, c=0.
- Backpressure: hold out_ready=0 for 5 cycles → f/flags stable, in_ready=0, new in_valid ignored. Then assert out_ready → IDLE next cycle.
- Assert rst during MUL BUSY → next cycle in_ready=1, out_valid=0, z=1, c=0; a following ADC uses c_prev=0. Reserved op 13 → f=0xFF, c=0, v=0.
